// File: rtl/therm_pkg.sv
// Shared types and default constants for the thermistor ADC sampling path.
package therm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_e;

  localparam int DEF_CLK_DIV       = 4;
  localparam int DEF_ADC_BITS      = 12;
  localparam int DEF_AVG_LOG2      = 3;
  localparam int DEF_SAMPLE_PERIOD = 1000;
  localparam int DEF_OUT_BITS      = 4;

  function automatic int acc_width(input int adc_bits, input int avg_log2);
    return adc_bits + avg_log2;
  endfunction

  localparam int ACC_W = acc_width(DEF_ADC_BITS, DEF_AVG_LOG2);

endpackage

// File: rtl/therm_spi_rx.sv
// Read-only SPI receiver: frames one ADC conversion and shifts it in MSB first.
//
// state    | meaning
// IDLE     | cs_n high, waiting for start
// SETUP    | cs_n low, sclk low, CLK_DIV cycles before the first bit
// SHIFT_LO | sclk low half-period; miso captured on exit
// SHIFT_HI | sclk high half-period; last bit exits to DONE
// DONE     | cs_n high for one cycle, sample handed to the accumulator
module therm_spi_rx
  import therm_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int ADC_BITS = DEF_ADC_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                miso,
  output logic                cs_n,
  output logic                sclk,
  output logic                busy,
  output logic                idle,
  output logic                done,
  output logic [ADC_BITS-1:0] sample
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(ADC_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(ADC_BITS - 1);

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [ADC_BITS-1:0] shreg_q;
  logic                cs_n_q;
  logic                sclk_q;
  logic                busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            div_q   <= DIV_LOAD;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (div_q == '0) begin
            state_q <= SHIFT_LO;
            div_q   <= DIV_LOAD;
            bit_q   <= BIT_LOAD;
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        SHIFT_LO: begin
          if (div_q == '0) begin
            state_q <= SHIFT_HI;
            div_q   <= DIV_LOAD;
            sclk_q  <= 1'b1;
            shreg_q <= {shreg_q[ADC_BITS-2:0], miso};
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_q == '0) begin
            div_q  <= DIV_LOAD;
            sclk_q <= 1'b0;
            if (bit_q == '0) begin
              state_q <= DONE;
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= SHIFT_LO;
              bit_q   <= bit_q - BIT_W'(1);
            end
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // done fires on the edge that enters DONE so the top can register the result alongside cs_n rising
  assign done   = (state_q == SHIFT_HI) && (div_q == '0) && (bit_q == '0);
  assign idle   = (state_q == IDLE);
  assign sample = shreg_q;
  assign cs_n   = cs_n_q;
  assign sclk   = sclk_q;
  assign busy   = busy_q;

endmodule

// File: rtl/therm_adc_sampler.sv
// Periodic thermistor ADC sampler: period timer, box-car accumulator and averaged output code.
module therm_adc_sampler
  import therm_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int ADC_BITS      = DEF_ADC_BITS,
  parameter int AVG_LOG2      = DEF_AVG_LOG2,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int OUT_BITS      = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                adc_miso,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [OUT_BITS-1:0] v_therm,
  output logic                v_valid,
  output logic                busy
);

  localparam int AW    = acc_width(ADC_BITS, AVG_LOG2);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SAMPLE_PERIOD - 1);

  logic                rx_done;
  logic                rx_idle;
  logic [ADC_BITS-1:0] rx_sample;
  logic                start;

  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AW-1:0]       sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic [OUT_BITS-1:0] v_therm_q, v_therm_d;
  logic                v_valid_q, v_valid_d;

  therm_spi_rx #(
    .CLK_DIV  (CLK_DIV),
    .ADC_BITS (ADC_BITS)
  ) u_spi_rx (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .miso   (adc_miso),
    .cs_n   (adc_cs_n),
    .sclk   (adc_sclk),
    .busy   (busy),
    .idle   (rx_idle),
    .done   (rx_done),
    .sample (rx_sample)
  );

  // Down-counter phase: zero marks a conversion start and is held while disabled.
  assign start = en && (timer_q == '0) && rx_idle;

  always_comb begin
    timer_d   = timer_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    v_therm_d = v_therm_q;
    v_valid_d = 1'b0;
    sum       = acc_q + AW'(rx_sample);

    if (!en)                 timer_d = '0;
    else if (timer_q == '0)  timer_d = TMR_LOAD;
    else                     timer_d = timer_q - TMR_W'(1);

    // Remembers that en dropped at some point during the conversion in flight
    if (start)    drop_d = 1'b0;
    else if (!en) drop_d = 1'b1;

    if (rx_done) begin
      if (drop_q || !en) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (cnt_q == '1) begin
        v_therm_d = sum[AW-1 -: OUT_BITS];
        v_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + AVG_LOG2'(1);
      end
    end else if (rx_idle && !en) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      v_therm_q <= '0;
      v_valid_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      v_therm_q <= v_therm_d;
      v_valid_q <= v_valid_d;
    end
  end

  assign v_therm = v_therm_q;
  assign v_valid = v_valid_q;

endmodule

// File: tb/tb_therm_adc_sampler.sv
// Self-checking bench for therm_adc_sampler: ADC word model, batch-average reference and protocol timing checks.
module tb_therm_adc_sampler;

  localparam int CLK_DIV       = 4;
  localparam int ADC_BITS      = 12;
  localparam int AVG_LOG2      = 3;
  localparam int SAMPLE_PERIOD = 1000;
  localparam int OUT_BITS      = 4;
  localparam int NAVG          = 1 << AVG_LOG2;
  localparam int CONV_LEN      = CLK_DIV * (1 + 2 * ADC_BITS);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en  = 1'b0;
  logic                adc_miso = 1'b0;
  logic                adc_cs_n;
  logic                adc_sclk;
  logic [OUT_BITS-1:0] v_therm;
  logic                v_valid;
  logic                busy;

  always #5 clk = ~clk;

  therm_adc_sampler #(
    .CLK_DIV       (CLK_DIV),
    .ADC_BITS      (ADC_BITS),
    .AVG_LOG2      (AVG_LOG2),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .OUT_BITS      (OUT_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .adc_miso (adc_miso),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .v_therm  (v_therm),
    .v_valid  (v_valid),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within budget (t=%0t)", name, $time);
  endtask

  // ADC word source, selected by the stimulus
  int                  mode = 1;
  logic [ADC_BITS-1:0] fixed_w = '0;
  logic [ADC_BITS-1:0] alt_a = '0;
  logic [ADC_BITS-1:0] alt_b = '0;
  bit                  alt_sel = 1'b0;

  // Monitor / reference model state
  int                          cyc = 0;
  int                          falls = 0;
  int                          last_fall = 0;
  bit                          spacing_valid = 1'b0;
  bit                          cs_prev = 1'b1;
  bit                          sclk_prev = 1'b0;
  bit                          en_prev = 1'b0;
  bit                          rose_prev = 1'b0;
  bit                          rose_now;
  bit                          idle_prev;
  bit                          in_conv = 1'b0;
  bit                          conv_ok = 1'b0;
  logic [ADC_BITS-1:0]         conv_word = '0;
  int                          rise_cnt = 0;
  int                          lo_run = 0;
  int                          hi_run = 0;
  int                          low_len = 0;
  logic [therm_pkg::ACC_W-1:0] batch_sum = '0;
  int                          batch_n = 0;
  logic [OUT_BITS-1:0]         exp_vtherm = '0;
  bit                          exp_valid;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_cs_n", adc_cs_n, 1);
      chk("rst_sclk", adc_sclk, 0);
      chk("rst_v_therm", v_therm, 0);
      chk("rst_v_valid", v_valid, 0);
      chk("rst_busy", busy, 0);
      in_conv       = 1'b0;
      batch_sum     = '0;
      batch_n       = 0;
      exp_vtherm    = '0;
      spacing_valid = 1'b0;
      rise_cnt      = 0;
      cs_prev       = 1'b1;
      sclk_prev     = 1'b0;
      rose_prev     = 1'b0;
      en_prev       = en;
      adc_miso      = 1'b0;
    end else begin
      exp_valid = 1'b0;
      rose_now  = 1'b0;
      idle_prev = cs_prev && !rose_prev;

      if (!adc_cs_n && cs_prev) begin
        falls++;
        if (spacing_valid) chk("start_spacing", cyc - last_fall, SAMPLE_PERIOD);
        last_fall     = cyc;
        spacing_valid = 1'b1;
        in_conv       = 1'b1;
        conv_ok       = 1'b1;
        rise_cnt      = 0;
        lo_run        = 0;
        hi_run        = 0;
        low_len       = 0;
        case (mode)
          0:       conv_word = ADC_BITS'($urandom_range(0, (1 << ADC_BITS) - 1));
          2: begin
            conv_word = alt_sel ? alt_b : alt_a;
            alt_sel   = ~alt_sel;
          end
          default: conv_word = fixed_w;
        endcase
      end

      if (en && !en_prev && idle_prev) chk("start_latency_cs_n", adc_cs_n, 0);

      if (!en) spacing_valid = 1'b0;
      else if (spacing_valid && (cyc - last_fall > SAMPLE_PERIOD)) begin
        chk("start_overdue", cyc - last_fall, SAMPLE_PERIOD);
        spacing_valid = 1'b0;
      end

      if (in_conv && !adc_cs_n) begin
        low_len++;
        if (!en) conv_ok = 1'b0;
        if (adc_sclk && !sclk_prev) begin
          rise_cnt++;
          chk("sclk_low_run", lo_run, (rise_cnt == 1) ? 2 * CLK_DIV : CLK_DIV);
          lo_run = 0;
          hi_run = 0;
        end
        if (!adc_sclk && sclk_prev) chk("sclk_high_run", hi_run, CLK_DIV);
        if (adc_sclk) hi_run++;
        else          lo_run++;
      end

      if (adc_cs_n && !cs_prev && in_conv) begin
        rose_now = 1'b1;
        in_conv  = 1'b0;
        if (!en) conv_ok = 1'b0;
        chk("cs_low_len", low_len, CONV_LEN);
        chk("sclk_rises", rise_cnt, ADC_BITS);
        chk("last_high_run", hi_run, CLK_DIV);
        if (conv_ok) begin
          batch_sum = batch_sum + therm_pkg::ACC_W'(conv_word);
          batch_n++;
          if (batch_n == NAVG) begin
            exp_valid  = 1'b1;
            exp_vtherm = OUT_BITS'((batch_sum >> AVG_LOG2) >> (ADC_BITS - OUT_BITS));
            batch_sum  = '0;
            batch_n    = 0;
          end
        end else begin
          batch_sum = '0;
          batch_n   = 0;
        end
      end

      if (idle_prev && !en) begin
        batch_sum = '0;
        batch_n   = 0;
      end

      chk("busy_vs_cs_n", busy, !adc_cs_n);
      if (adc_cs_n) chk("sclk_idle", adc_sclk, 0);
      chk("v_valid", v_valid, exp_valid);
      chk("v_therm", v_therm, exp_vtherm);

      adc_miso  = (in_conv && rise_cnt < ADC_BITS) ? conv_word[ADC_BITS-1-rise_cnt] : 1'b0;
      cs_prev   = adc_cs_n;
      sclk_prev = adc_sclk;
      en_prev   = en;
      rose_prev = rose_now;
    end
  end

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (v_valid !== 1'b1 && n < 9000);
    if (v_valid !== 1'b1) timeout(name);
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int n;

    // Reset, then idle with en low
    repeat (3) @(negedge clk);
    chk("reset_v_therm", v_therm, 0);
    chk("reset_cs_n", adc_cs_n, 1);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_cs_n", adc_cs_n, 1);

    // Full-scale: no overflow, top nibble F
    #1 mode = 1; fixed_w = 12'hFFF; en = 1'b1;
    f0 = falls;
    wait_valid("valid_fff");
    chk("lit_fff", v_therm, 4'hF);
    chk("batch_len_fff", falls - f0, NAVG);

    // Alternating 7FF/801 averages to 800
    #1 mode = 2; alt_a = 12'h7FF; alt_b = 12'h801; alt_sel = 1'b0;
    wait_valid("valid_alt");
    chk("lit_alt", v_therm, 4'h8);

    // Truncation, no rounding
    #1 mode = 1; fixed_w = 12'h7FF;
    wait_valid("valid_7ff");
    chk("lit_7ff", v_therm, 4'h7);

    // MSB-first capture
    #1 fixed_w = 12'hA5C;
    wait_valid("valid_a5c");
    chk("lit_a5c", v_therm, 4'hA);

    // en dropped during the 3rd conversion of a batch
    #1 fixed_w = 12'h123;
    f0 = falls;
    n = 0;
    while (falls < f0 + 3 && n < 4000) begin @(negedge clk); n++; end
    if (falls < f0 + 3) timeout("third_conversion");
    repeat (20) @(negedge clk);
    #1 en = 1'b0;
    n = 0;
    while (adc_cs_n !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (adc_cs_n !== 1'b1) timeout("drop_conv_end");
    repeat (5) @(negedge clk);
    chk("held_v_therm", v_therm, 4'hA);
    #1 en = 1'b1;
    f0 = falls;
    wait_valid("valid_refill");
    chk("refill_batch_len", falls - f0, NAVG);
    chk("lit_123", v_therm, 4'h1);

    // rst during SHIFT_HI of bit 5
    #1 fixed_w = 12'h3C4;
    n = 0;
    while (!(rise_cnt == 5 && adc_sclk === 1'b1 && adc_cs_n === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(rise_cnt == 5 && adc_sclk === 1'b1)) timeout("bit5_high");
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", adc_cs_n, 1);
    chk("midrst_sclk", adc_sclk, 0);
    chk("midrst_v_therm", v_therm, 0);
    chk("midrst_v_valid", v_valid, 0);
    #1 rst = 1'b0;
    f0 = falls;
    wait_valid("valid_after_rst");
    chk("lit_3c4", v_therm, 4'h3);
    chk("post_rst_batch_len", falls - f0, NAVG);

    // Random words, then a random-length disable gap and another random batch
    #1 mode = 0;
    wait_valid("valid_rand1");
    #1 en = 1'b0;
    repeat ($urandom_range(1, 50)) @(negedge clk);
    #1 en = 1'b1;
    wait_valid("valid_rand2");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
